// File: rtl/psum_pkg.sv
// psum_pkg: shared defaults, beat-count helper and TX FSM encodings for the psum AXIS transmitter
package psum_pkg;
  localparam int PSUM_W_D = 5;
  localparam int MAC_NUM_D = 256;
  localparam int TDATA_W_D = 32;
  localparam int PKT_LEN_W_D = 16;
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_LOAD = 2'd1;
  localparam logic [1:0] TX_SEND = 2'd2;
  function automatic int beats_of(input int vec_w, input int tdata_w);
    return vec_w / tdata_w;
  endfunction
endpackage

// File: rtl/psum_vec_buffer.sv
// psum_vec_buffer: 2-entry vector FIFO (wr/wr_data in, rd pops head, rd_data = head, full/empty flags)
module psum_vec_buffer #(
  parameter int W = 1280
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic [1:0]   cnt;
  assign rd_data = mem[rp];
  assign full = cnt[1];
  assign empty = cnt == 2'd0;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      wp <= wp ^ wr;
      rp <= rp ^ rd;
      cnt <= cnt + 2'(wr) - 2'(rd);
    end
endmodule

// File: rtl/psum_axis_tx.sv
// psum_axis_tx: buffers psum vectors and streams them as 32-bit AXIS beats framed into pkt_len-vector packets
// Ports: clk, rst (async high); psum_in/psum_valid from MAC array; pkt_len; M_AXIS_* master; buf_full, overflow, tx_busy status
module psum_axis_tx
  import psum_pkg::*;
#(
  parameter int MAC_NUM = MAC_NUM_D,
  parameter int PSUM_W = PSUM_W_D,
  parameter int C_M_AXIS_TDATA_WIDTH = TDATA_W_D,
  parameter int PKT_LEN_W = PKT_LEN_W_D
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PSUM_W*MAC_NUM-1:0]         psum_in,
  input  logic                              psum_valid,
  input  logic [PKT_LEN_W-1:0]              pkt_len,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              buf_full,
  output logic                              overflow,
  output logic                              tx_busy
);
  localparam int VW = PSUM_W * MAC_NUM;
  localparam int TW = C_M_AXIS_TDATA_WIDTH;
  localparam int BEATS = beats_of(VW, TW);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [1:0]           state;
  logic [VW-1:0]        sr, head;
  logic [BW-1:0]        beat_cnt;
  logic [PKT_LEN_W-1:0] vec_cnt, pkt_target, tgt;
  logic                 tvalid, tlast, hs, last_beat, last_vec, load, rd_en, wr_en, full, empty;
  psum_vec_buffer #(.W(VW)) u_buf (
    .clk(clk), .rst(rst), .wr(wr_en), .wr_data(psum_in),
    .rd(rd_en), .rd_data(head), .full(full), .empty(empty)
  );
  assign hs = tvalid & M_AXIS_TREADY;
  assign last_beat = beat_cnt == BW'(BEATS - 1);
  // the slot is released on the last-beat handshake, so a write may land in the same cycle
  assign rd_en = hs & last_beat;
  assign wr_en = psum_valid & (~full | rd_en);
  // from IDLE the copy happens immediately; after a vector, LOAD is the single bubble cycle
  assign load = (state == TX_IDLE & ~empty) | state == TX_LOAD;
  // packet length is sampled only when a new packet begins
  assign tgt = vec_cnt == '0 ? (pkt_len == '0 ? PKT_LEN_W'(1) : pkt_len) : pkt_target;
  assign last_vec = vec_cnt == pkt_target - PKT_LEN_W'(1);
  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA = sr[TW-1:0];
  assign M_AXIS_TSTRB = '1;
  assign M_AXIS_TLAST = tlast;
  assign buf_full = full;
  assign tx_busy = ~empty | state != TX_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= TX_IDLE;
      sr <= '0;
      beat_cnt <= '0;
      vec_cnt <= '0;
      pkt_target <= '0;
      tvalid <= 1'b0;
      tlast <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | (psum_valid & ~wr_en);
      if (load) begin
        state <= TX_SEND;
        sr <= head;
        tvalid <= 1'b1;
        beat_cnt <= '0;
        pkt_target <= tgt;
        tlast <= BEATS == 1 && vec_cnt == tgt - PKT_LEN_W'(1);
      end else if (hs) begin
        if (last_beat) begin
          state <= (full | wr_en) ? TX_LOAD : TX_IDLE;
          tvalid <= 1'b0;
          tlast <= 1'b0;
          beat_cnt <= '0;
          vec_cnt <= last_vec ? '0 : vec_cnt + PKT_LEN_W'(1);
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
          sr <= sr >> TW;
          tlast <= beat_cnt == BW'(BEATS - 2) && last_vec;
        end
      end
    end
endmodule

// File: tb/tb_psum_axis_tx.sv
// tb_psum_axis_tx: scoreboard bench for psum_axis_tx (table scenarios plus latency/overflow/same-cycle/reset sequences)
module tb_psum_axis_tx;
  localparam int VW = 1280;
  localparam int BEATS = 40;
  localparam int LIMIT = 5000;
  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;
  typedef struct {
    int len;
    int nvec;
    int gap;
    int rdy;
    int exp_beats;
  } vec_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] psum_in = '0;
  logic          psum_valid = 1'b0;
  logic [15:0]   pkt_len = 16'd1;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY = 1'b0;
  logic [31:0]   M_AXIS_TDATA;
  logic [3:0]    M_AXIS_TSTRB;
  logic          buf_full, overflow, tx_busy;
  beat_t         sb[$];
  int            checks = 0, errors = 0, hs_cnt = 0, rdy_pct = 100, m_vc = 0, m_tgt = 1;
  psum_axis_tx dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .psum_valid(psum_valid), .pkt_len(pkt_len),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .buf_full(buf_full), .overflow(overflow), .tx_busy(tx_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < BEATS; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction
  task automatic push_vec(input logic [VW-1:0] v);
    beat_t b;
    if (m_vc == 0) m_tgt = pkt_len == 0 ? 1 : int'(pkt_len);
    for (int k = 0; k < BEATS; k++) begin
      b.d = v[32*k +: 32];
      b.l = k == BEATS - 1 && m_vc == m_tgt - 1;
      sb.push_back(b);
    end
    m_vc = m_vc == m_tgt - 1 ? 0 : m_vc + 1;
  endtask
  task automatic pulse(input logic [VW-1:0] v, input bit exp);
    if (exp) push_vec(v);
    @(posedge clk);
    #1 psum_in = v;
    psum_valid = 1'b1;
    @(posedge clk);
    #1 psum_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || tx_busy) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n >= LIMIT), 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    m_vc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial forever begin
    @(posedge clk);
    #1 M_AXIS_TREADY = rdy_pct >= 100 ? 1'b1 : rdy_pct <= 0 ? 1'b0 : $urandom_range(0, 99) < rdy_pct;
  end
  initial begin
    bit          prev_stall = 0, prev_last = 0;
    logic [31:0] prev_data = '0;
    beat_t       e;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 0;
      else begin
        if (prev_stall) chk("stall_hold", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, {1'b1, prev_last, prev_data});
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          hs_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", M_AXIS_TDATA, M_AXIS_TLAST);
          end else begin
            e = sb.pop_front();
            chk("beat", {M_AXIS_TLAST, M_AXIS_TDATA}, {e.l, e.d});
          end
        end
        prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_data = M_AXIS_TDATA;
        prev_last = M_AXIS_TLAST;
      end
    end
  end
  initial begin
    vec_t          tbl[4];
    logic [VW-1:0] v;
    int            base, n;
    tbl[0] = '{1, 2, 0, 100, 80};
    tbl[1] = '{3, 3, 8, 100, 120};
    tbl[2] = '{2, 4, 3, 50, 160};
    tbl[3] = '{0, 2, 5, 70, 80};
    #3 chk("reset_outputs", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, buf_full, overflow, tx_busy}, '0);
    chk("tstrb", M_AXIS_TSTRB, 4'hF);
    @(posedge clk);
    #1 rst = 1'b0;
    base = hs_cnt;
    v = '0;
    v[0] = 1'b1;
    push_vec(v);
    @(posedge clk);
    #1 psum_in = v;
    psum_valid = 1'b1;
    @(negedge clk) chk("lat_n0", M_AXIS_TVALID, 0);
    @(posedge clk);
    #1 psum_valid = 1'b0;
    @(negedge clk) chk("lat_n1", M_AXIS_TVALID, 0);
    @(negedge clk) chk("lat_n2", {M_AXIS_TVALID, M_AXIS_TDATA}, {1'b1, 32'h1});
    drain();
    chk("lat_beats", hs_cnt - base, BEATS);
    foreach (tbl[i]) begin
      rdy_pct = tbl[i].rdy;
      pkt_len = 16'(tbl[i].len);
      base = hs_cnt;
      for (int j = 0; j < tbl[i].nvec; j++) begin
        n = 0;
        @(negedge clk);
        while (buf_full && n < LIMIT) begin
          @(negedge clk);
          n++;
        end
        chk("slot_timeout", 64'(n >= LIMIT), 0);
        pulse(rand_vec(), 1);
        repeat (tbl[i].gap) @(posedge clk);
      end
      drain();
      chk($sformatf("tbl%0d_beats", i), hs_cnt - base, tbl[i].exp_beats);
      chk($sformatf("tbl%0d_overflow", i), overflow, 0);
    end
    rdy_pct = 0;
    pkt_len = 16'd1;
    base = hs_cnt;
    pulse(rand_vec(), 1);
    repeat (2) @(posedge clk);
    pulse(rand_vec(), 1);
    @(negedge clk) chk("ovf_full", {buf_full, overflow}, 2'b10);
    pulse(rand_vec(), 0);
    @(negedge clk) chk("ovf_set", {buf_full, overflow}, 2'b11);
    pulse(rand_vec(), 0);
    rdy_pct = 100;
    drain();
    chk("ovf_beats", hs_cnt - base, 2 * BEATS);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    @(negedge clk) chk("ovf_cleared", overflow, 0);
    rdy_pct = 0;
    base = hs_cnt;
    pulse(rand_vec(), 1);
    pulse(rand_vec(), 1);
    v = rand_vec();
    push_vec(v);
    @(negedge clk) chk("same_full", buf_full, 1);
    rdy_pct = 100;
    n = 0;
    @(negedge clk);
    while (!(M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("same_last_timeout", 64'(n >= LIMIT), 0);
    psum_in = v;
    psum_valid = 1'b1;
    @(posedge clk);
    #1 psum_valid = 1'b0;
    @(negedge clk) chk("same_accept", {buf_full, overflow}, 2'b10);
    drain();
    chk("same_beats", hs_cnt - base, 3 * BEATS);
    chk("same_overflow", overflow, 0);
    pkt_len = 16'd2;
    for (int k = 0; k < BEATS; k++) v[32*k +: 32] = 32'hA000 + k;
    pulse(v, 1);
    n = 0;
    @(negedge clk);
    while (!(M_AXIS_TVALID && M_AXIS_TDATA == 32'hA011) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("rst17_timeout", 64'(n >= LIMIT), 0);
    #2 rst = 1'b1;
    #1 chk("rst17_async", {M_AXIS_TVALID, M_AXIS_TLAST, tx_busy, buf_full}, '0);
    sb.delete();
    m_vc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    base = hs_cnt;
    pulse(rand_vec(), 1);
    pulse(rand_vec(), 1);
    drain();
    chk("rst17_beats", hs_cnt - base, 2 * BEATS);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
